// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, default bit timing and receiver state encoding.
// Receiver parity support is selected by the UART_RX_PARITY_EN macro.
package uart_pkg;

  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StStart    = 3'd1;
  localparam logic [2:0] StData     = 3'd2;
  localparam logic [2:0] StParity   = 3'd3;
  localparam logic [2:0] StStop     = 3'd4;
  localparam logic [2:0] StWaitHigh = 3'd5;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous input; both flops reset to 1 (idle line level).
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver for 8N1 frames, midpoint sampling, one-cycle completion/error strobes.
// Define UART_RX_PARITY_EN to accept 8E1 frames (even parity bit after D7).
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 SYSCLK,
  input  logic                 RESET_N,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] DATA,
  output logic                 BUSY_FLAG,
  output logic                 COMPLATE_FLAG,
  output logic                 ERROR_FLAG
);

  localparam int unsigned     TickW    = $clog2(CLKS_PER_BIT);
  localparam logic [TickW-1:0] TickFull = TickW'(CLKS_PER_BIT - 1);
  localparam logic [TickW-1:0] TickHalf = TickW'((CLKS_PER_BIT >> 1) - 1);
  localparam logic [2:0]       LastBit  = 3'(DATA_BITS - 1);

  logic                 rxs;
  logic [2:0]           state_q, state_d;
  logic [TickW-1:0]     tick_q, tick_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 parity_ok;

  uart_rx_sync u_rx_sync (
    .clk      (SYSCLK),
    .rst_n    (RESET_N),
    .async_in (RXD),
    .sync_out (rxs)
  );

`ifdef UART_RX_PARITY_EN
  logic parity_err_q, parity_err_d;

  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  always_comb begin
    parity_err_d = parity_err_q;
    if (state_q == StIdle) begin
      parity_err_d = 1'b0;
    end else if (state_q == StParity && tick_q == '0) begin
      parity_err_d = rxs ^ even_parity(shift_q);
    end
  end

  assign parity_ok = ~parity_err_q;
`else
  assign parity_ok = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      StIdle: begin
        bit_cnt_d = '0;
        tick_d    = TickHalf;
        if (!rxs) begin
          state_d = StStart;
        end
      end

      StStart: begin
        if (tick_q == '0) begin
          tick_d  = TickFull;
          // A start bit gone high again by mid-bit is a glitch: drop it silently.
          state_d = rxs ? StIdle : StData;
        end else begin
          tick_d = tick_q - TickW'(1);
        end
      end

      StData: begin
        if (tick_q == '0) begin
          tick_d  = TickFull;
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == LastBit) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          tick_d = tick_q - TickW'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (tick_q == '0) begin
          tick_d  = TickFull;
          state_d = StStop;
        end else begin
          tick_d = tick_q - TickW'(1);
        end
      end
`endif

      StStop: begin
        if (tick_q == '0) begin
          // Leaving at mid stop bit gives half a bit of margin for a back-to-back start.
          if (rxs && parity_ok) begin
            data_d  = shift_q;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            err_d   = 1'b1;
            state_d = StWaitHigh;
          end
        end else begin
          tick_d = tick_q - TickW'(1);
        end
      end

      StWaitHigh: begin
        if (rxs) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= StIdle;
      tick_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign DATA          = data_q;
  assign BUSY_FLAG     = (state_q != StIdle);
  assign COMPLATE_FLAG = done_q;
  assign ERROR_FLAG    = err_q;

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver for 8N1 frames (optionally 8E1), the receive-side counterpart of the team's UART transmitter. Samples the asynchronous RXD pin through a 2-FF synchronizer, detects start bits, samples each bit at its midpoint, and presents the received byte with a one-cycle completion strobe. It sits between the board RX pin and the byte-consuming logic (command parser or FIFO).

## Interface
- CLKS_PER_BIT, 868, SYSCLK cycles per bit (100 MHz / 115200); legal range 4..65535
- SYSCLK  input  1  system clock; all logic on rising edge
- RESET_N  input  1  asynchronous, active-low reset
- RXD  input  1  serial line, idle high, asynchronous to SYSCLK
- DATA  output  8  last received byte, LSB received first
- BUSY_FLAG  output  1  high while a frame is in progress (START through STOP)
- COMPLATE_FLAG  output  1  one-cycle pulse: valid frame received, DATA updated this cycle
- ERROR_FLAG  output  1  one-cycle pulse: framing error (or parity error, see Configuration)

## Operation
- Reset values: DATA=8'h00, BUSY_FLAG=0, COMPLATE_FLAG=0, ERROR_FLAG=0, state IDLE, synchronizer flops=1.
- RXD passes through 2-FF synchronizer; FSM uses synced value rxs only.
- States: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
- IDLE: on rxs==0 -> START, clear bit counter, load tick counter.
- START: after CLKS_PER_BIT/2 cycles sample rxs; 0 -> DATA; 1 -> IDLE (glitch, no flags).
- DATA: every CLKS_PER_BIT cycles sample rxs into shift register MSB, shift right; after 8th sample -> PARITY or STOP.
- STOP: after CLKS_PER_BIT cycles sample rxs. 1 and no parity error: DATA<=shift reg, COMPLATE_FLAG pulse, -> IDLE. Otherwise: ERROR_FLAG pulse, DATA unchanged, -> WAIT_HIGH.
- WAIT_HIGH: stay until rxs==1, then IDLE (break / stuck-low line produces exactly one ERROR_FLAG).
- BUSY_FLAG = (state != IDLE).
- Tick counter width $clog2(CLKS_PER_BIT); half-bit value is CLKS_PER_BIT>>1 (floor).
- COMPLATE_FLAG and ERROR_FLAG are mutually exclusive; never both high.

## Timing
- Returning to IDLE at stop-bit midpoint lets a back-to-back start bit be detected with half-bit margin; no idle gap required between frames.
- Latency, first falling RXD edge to COMPLATE_FLAG: 2 (sync) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles, +/-1 for edge phase (+1 bit with parity).
- DATA holds its value until the next valid frame; stable in the cycle COMPLATE_FLAG is high and after.
- Glitch low shorter than CLKS_PER_BIT/2 - 2 cycles is rejected.
- RESET_N assertion mid-frame: immediate return to reset values; partial byte discarded, no flag pulses; first frame after release requires RXD high for at least one cycle before start edge.

## Configuration
- UART_RX_PARITY_EN defined: one even-parity bit follows D7 (PARITY state, sampled at midpoint); mismatch makes STOP exit via ERROR_FLAG even if stop bit is 1; frame length 11 bits.
- Undefined: 8N1 only, PARITY state and parity logic absent; ports identical either way.

## Structure
- Shared package uart_pkg: state encoding constants, DATA_BITS=8, default CLKS_PER_BIT, shared with the transmitter.
- Sub-module uart_rx_sync: 2-FF synchronizer, reset value 1, reusable for other async inputs.

## Test plan
- CLKS_PER_BIT=16, send 0xA5 8N1 -> one COMPLATE_FLAG pulse, DATA=0xA5, BUSY_FLAG high for ~152 cycles, ERROR_FLAG never high.
- Back-to-back 0x00 then 0xFF, no idle gap -> two COMPLATE_FLAG pulses 160 cycles apart, DATA 0x00 then 0xFF.
- 0x3C with stop bit forced 0, line held low 40 cycles -> exactly one ERROR_FLAG pulse, no COMPLATE_FLAG, DATA keeps prior value, next frame 0x81 received correctly.
- RXD low pulse of 4 cycles while idle -> BUSY_FLAG pulses briefly, no COMPLATE_FLAG/ERROR_FLAG.
- RESET_N low for 3 cycles during bit 4 of 0x55 -> all outputs reset, no flags; following 0x66 received as 0x66.
- UART_RX_PARITY_EN: 0x07 with parity 1 -> COMPLATE_FLAG, DATA=0x07; same byte with parity 0 -> ERROR_FLAG only.
